ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
// Two-master AHB arbiter/mux in front of the shared AHB port of the BIU.
// Master 0 is the MMU page-table walker. Master 1 is the cache bus unit.
// Consumes each master's bus_req and returns bus_ack, then routes the granted master's
// address phase and the data-phase owner's hwdata onto the single AHB master port.
// PARAMETERS
// AW  64  address width
// DW  64  data width
// RR  0   0: fixed priority, m0 wins; 1: round-robin, last-granted master loses ties
// PORTS
// clk             in   1   clock
// rst             in   1   synchronous reset, active-high
// m{0,1}_bus_req  in   1   master requests bus (level, held until its transfer completes)
// m{0,1}_bus_ack  out  1   grant (level)
// m{0,1}_haddr    in   AW  address-phase signals of master x:
// m{0,1}_hwrite   in   1     write
// m{0,1}_hsize    in   3     size
// m{0,1}_hburst   in   3     burst type
// m{0,1}_hprot    in   4     protection
// m{0,1}_htrans   in   2     transfer type
// m{0,1}_hmastlock in  1     locked transfer
// m{0,1}_hwdata   in   DW  write data (data phase)
// m{0,1}_hready   out  1   hready gated to master x
// m{0,1}_hresp    out  1   hresp gated to master x
// m{0,1}_hrdata   out  DW  hrdata broadcast, ungated
// haddr,hwrite,hsize,hburst,hprot,htrans,hmastlock,hwdata  out  AHB master port
// hready          in   1   AHB ready
// hresp           in   1   AHB error
// hrdata          in   DW  AHB read data
// BEHAVIOUR
// - Reset: state=IDLE, both bus_ack=0, last=1, dp_owner=NONE.
//   All AHB outputs 0; htrans=IDLE(2'b00).
// - States: IDLE, OWN0, OWN1, HANDOVER. bus_ackx = (state==OWNx), registered.
// - Grant latency: one cycle after bus_req is first sampled high in IDLE.
// - IDLE: m0_req&!m1_req->OWN0; m1_req&!m0_req->OWN1.
//   Both requesting: RR=0 -> OWN0; RR=1 -> master != last. Entering OWNx sets last=x.
// - OWNx: the AHB port carries master x's address-phase signals combinationally.
//   On !mx_bus_req & !mx_hmastlock -> HANDOVER; ack drops on the same edge.
//   A request from the other master never pre-empts. hresp never revokes a grant.
// - HANDOVER: outputs forced to the reset values (htrans=IDLE).
//   Exit only on hready=1, with the same decision as IDLE.
//   So handover costs >=1 idle cycle and never overlaps two owners' data phases.
// - Data-phase tracking: on each hready=1 edge, dp_owner <= address-phase owner
//   (NONE in IDLE/HANDOVER). Otherwise dp_owner holds.
// - hwdata = hwdata of dp_owner, or 0 when dp_owner=NONE.
// - mx_hready = hready & (state==OWNx | dp_owner==x); mx_hresp = hresp under the same gate.
//   A non-owner always sees hready=0 and hresp=0.
// - hready low stretches any state. No counter or FSM advances except on the paths above.
// - Reset asserted mid-transfer: next edge returns to reset values, with no partial grant retained.
// STRUCTURE
// - ahb_defs.vh shared include: HTRANS_IDLE/NSEQ/SEQ, HBURST_SINGLE/INCR, arbiter state codes.
// - One sub-module, ahb_master_mux: combinational 2:1 select of the address-phase bundle
//   plus the hwdata select. The FSM, last and dp_owner live in the top.
// TESTING
// - m1 only: req@t0 -> ack@t1; haddr=m1_haddr from t1.
//   Drop req@t5 -> ack=0@t6; htrans=IDLE while HANDOVER.
// - Both req in IDLE, RR=0 -> m0 granted.
//   m0 drops, hready=1 -> exactly one IDLE cycle, then m1 acked.
// - RR=1: both req held, each drops after one transfer -> grants alternate m0,m1,m0.
// - m1 INCR burst of 256 beats (NSEQ then SEQ) with m0 req mid-burst ->
//   m0_ack stays 0 until m1 drops req; all 256 m1_hready pulses delivered to m1 only.
// - HANDOVER with hready held 0 for 3 cycles -> no new ack until hready=1;
//   last write data still routed from old owner on hwdata.
// - hresp=1 during m1 read -> m1_hresp=1 and m0_hresp=0; m1 keeps its grant until req drops.
// - rst pulsed while OWN1 with htrans=SEQ -> next cycle both acks=0 and htrans=IDLE.

Source files
------------

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings, arbiter state/owner types and the grant decision
// used by the two-master AHB arbiter.
package ahb_bus_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN0     = 2'd1,
        ST_OWN1     = 2'd2,
        ST_HANDOVER = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // Grant decision from an unowned bus; last_m1 marks m1 as the most recent winner.
    function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                            input logic last_m1, input logic rr_en);
        arb_state_e pick;
        pick = ST_IDLE;
        if (req0 && req1) begin
            pick = (rr_en && !last_m1) ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
            pick = ST_OWN0;
        end else if (req1) begin
            pick = ST_OWN1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ahb_master_mux.sv
// Combinational 2:1 routing of the address-phase bundle (by address owner)
// and of hwdata (by data-phase owner); an unowned phase drives idle zeros.
module ahb_master_mux
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  owner_e          addr_sel,
    input  owner_e          data_sel,
    input  logic [AW-1:0]   m0_haddr,
    input  logic            m0_hwrite,
    input  logic [2:0]      m0_hsize,
    input  logic [2:0]      m0_hburst,
    input  logic [3:0]      m0_hprot,
    input  logic [1:0]      m0_htrans,
    input  logic            m0_hmastlock,
    input  logic [DW-1:0]   m0_hwdata,
    input  logic [AW-1:0]   m1_haddr,
    input  logic            m1_hwrite,
    input  logic [2:0]      m1_hsize,
    input  logic [2:0]      m1_hburst,
    input  logic [3:0]      m1_hprot,
    input  logic [1:0]      m1_htrans,
    input  logic            m1_hmastlock,
    input  logic [DW-1:0]   m1_hwdata,
    output logic [AW-1:0]   haddr,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    output logic [3:0]      hprot,
    output logic [1:0]      htrans,
    output logic            hmastlock,
    output logic [DW-1:0]   hwdata
);

    always_comb begin
        haddr     = '0;
        hwrite    = 1'b0;
        hsize     = 3'b000;
        hburst    = HBURST_SINGLE;
        hprot     = 4'b0000;
        htrans    = HTRANS_IDLE;
        hmastlock = 1'b0;
        unique case (addr_sel)
            OWN_M0: begin
                haddr     = m0_haddr;
                hwrite    = m0_hwrite;
                hsize     = m0_hsize;
                hburst    = m0_hburst;
                hprot     = m0_hprot;
                htrans    = m0_htrans;
                hmastlock = m0_hmastlock;
            end
            OWN_M1: begin
                haddr     = m1_haddr;
                hwrite    = m1_hwrite;
                hsize     = m1_hsize;
                hburst    = m1_hburst;
                hprot     = m1_hprot;
                htrans    = m1_htrans;
                hmastlock = m1_hmastlock;
            end
            default: ;
        endcase
    end

    always_comb begin
        hwdata = '0;
        unique case (data_sel)
            OWN_M0:  hwdata = m0_hwdata;
            OWN_M1:  hwdata = m1_hwdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter: m0 = page-table walker, m1 = cache bus unit.
// Grants are held until released, handover inserts an idle address phase.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int RR = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_bus_req,
    output logic            m0_bus_ack,
    input  logic [AW-1:0]   m0_haddr,
    input  logic            m0_hwrite,
    input  logic [2:0]      m0_hsize,
    input  logic [2:0]      m0_hburst,
    input  logic [3:0]      m0_hprot,
    input  logic [1:0]      m0_htrans,
    input  logic            m0_hmastlock,
    input  logic [DW-1:0]   m0_hwdata,
    output logic            m0_hready,
    output logic            m0_hresp,
    output logic [DW-1:0]   m0_hrdata,
    input  logic            m1_bus_req,
    output logic            m1_bus_ack,
    input  logic [AW-1:0]   m1_haddr,
    input  logic            m1_hwrite,
    input  logic [2:0]      m1_hsize,
    input  logic [2:0]      m1_hburst,
    input  logic [3:0]      m1_hprot,
    input  logic [1:0]      m1_htrans,
    input  logic            m1_hmastlock,
    input  logic [DW-1:0]   m1_hwdata,
    output logic            m1_hready,
    output logic            m1_hresp,
    output logic [DW-1:0]   m1_hrdata,
    output logic [AW-1:0]   haddr,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    output logic [3:0]      hprot,
    output logic [1:0]      htrans,
    output logic            hmastlock,
    output logic [DW-1:0]   hwdata,
    input  logic            hready,
    input  logic            hresp,
    input  logic [DW-1:0]   hrdata
);

    localparam logic RR_EN = (RR != 0);

    arb_state_e state, state_nxt;
    logic       last, last_nxt;
    owner_e     dp_owner;
    owner_e     addr_owner;

    assign addr_owner = (state == ST_OWN0) ? OWN_M0 :
                        (state == ST_OWN1) ? OWN_M1 : OWN_NONE;

    // A low hready stretches every state, so nothing moves without it.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        if (hready) begin
            unique case (state)
                ST_OWN0: begin
                    if (!m0_bus_req && !m0_hmastlock) state_nxt = ST_HANDOVER;
                end
                ST_OWN1: begin
                    if (!m1_bus_req && !m1_hmastlock) state_nxt = ST_HANDOVER;
                end
                default: begin
                    state_nxt = arb_pick(m0_bus_req, m1_bus_req, last, RR_EN);
                    if (state_nxt == ST_OWN0) begin
                        last_nxt = 1'b0;
                    end else if (state_nxt == ST_OWN1) begin
                        last_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            dp_owner <= OWN_NONE;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            if (hready) dp_owner <= addr_owner;
        end
    end

    assign m0_bus_ack = (state == ST_OWN0);
    assign m1_bus_ack = (state == ST_OWN1);

    // Ready/response reach a master only while it owns either bus phase.
    assign m0_hready = hready & ((state == ST_OWN0) || (dp_owner == OWN_M0));
    assign m0_hresp  = hresp  & ((state == ST_OWN0) || (dp_owner == OWN_M0));
    assign m1_hready = hready & ((state == ST_OWN1) || (dp_owner == OWN_M1));
    assign m1_hresp  = hresp  & ((state == ST_OWN1) || (dp_owner == OWN_M1));

    assign m0_hrdata = hrdata;
    assign m1_hrdata = hrdata;

    ahb_master_mux #(
        .AW (AW),
        .DW (DW)
    ) u_mux (
        .addr_sel     (addr_owner),
        .data_sel     (dp_owner),
        .m0_haddr     (m0_haddr),
        .m0_hwrite    (m0_hwrite),
        .m0_hsize     (m0_hsize),
        .m0_hburst    (m0_hburst),
        .m0_hprot     (m0_hprot),
        .m0_htrans    (m0_htrans),
        .m0_hmastlock (m0_hmastlock),
        .m0_hwdata    (m0_hwdata),
        .m1_haddr     (m1_haddr),
        .m1_hwrite    (m1_hwrite),
        .m1_hsize     (m1_hsize),
        .m1_hburst    (m1_hburst),
        .m1_hprot     (m1_hprot),
        .m1_htrans    (m1_htrans),
        .m1_hmastlock (m1_hmastlock),
        .m1_hwdata    (m1_hwdata),
        .haddr        (haddr),
        .hwrite       (hwrite),
        .hsize        (hsize),
        .hburst       (hburst),
        .hprot        (hprot),
        .htrans       (htrans),
        .hmastlock    (hmastlock),
        .hwdata       (hwdata)
    );

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are checked against an ownership-level reference model.
module tb_ahb_bus_arbiter;
    import ahb_bus_arbiter_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int VW = 20 + AW + 3 * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m0_bus_req, m1_bus_req;
    logic [AW-1:0] m0_haddr, m1_haddr;
    logic          m0_hwrite, m1_hwrite;
    logic [2:0]    m0_hsize, m1_hsize, m0_hburst, m1_hburst;
    logic [3:0]    m0_hprot, m1_hprot;
    logic [1:0]    m0_htrans, m1_htrans;
    logic          m0_hmastlock, m1_hmastlock;
    logic [DW-1:0] m0_hwdata, m1_hwdata;
    logic          hready, hresp;
    logic [DW-1:0] hrdata;

    logic          o_ack0 [2];
    logic          o_ack1 [2];
    logic [AW-1:0] o_haddr [2];
    logic          o_hwrite [2];
    logic [2:0]    o_hsize [2];
    logic [2:0]    o_hburst [2];
    logic [3:0]    o_hprot [2];
    logic [1:0]    o_htrans [2];
    logic          o_hmastlock [2];
    logic [DW-1:0] o_hwdata [2];
    logic          o_m0_hready [2];
    logic          o_m0_hresp [2];
    logic          o_m1_hready [2];
    logic          o_m1_hresp [2];
    logic [DW-1:0] o_m0_hrdata [2];
    logic [DW-1:0] o_m1_hrdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_bus_arbiter #(.AW(AW), .DW(DW), .RR(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .m0_bus_req   (m0_bus_req),
            .m0_bus_ack   (o_ack0[g]),
            .m0_haddr     (m0_haddr),
            .m0_hwrite    (m0_hwrite),
            .m0_hsize     (m0_hsize),
            .m0_hburst    (m0_hburst),
            .m0_hprot     (m0_hprot),
            .m0_htrans    (m0_htrans),
            .m0_hmastlock (m0_hmastlock),
            .m0_hwdata    (m0_hwdata),
            .m0_hready    (o_m0_hready[g]),
            .m0_hresp     (o_m0_hresp[g]),
            .m0_hrdata    (o_m0_hrdata[g]),
            .m1_bus_req   (m1_bus_req),
            .m1_bus_ack   (o_ack1[g]),
            .m1_haddr     (m1_haddr),
            .m1_hwrite    (m1_hwrite),
            .m1_hsize     (m1_hsize),
            .m1_hburst    (m1_hburst),
            .m1_hprot     (m1_hprot),
            .m1_htrans    (m1_htrans),
            .m1_hmastlock (m1_hmastlock),
            .m1_hwdata    (m1_hwdata),
            .m1_hready    (o_m1_hready[g]),
            .m1_hresp     (o_m1_hresp[g]),
            .m1_hrdata    (o_m1_hrdata[g]),
            .haddr        (o_haddr[g]),
            .hwrite       (o_hwrite[g]),
            .hsize        (o_hsize[g]),
            .hburst       (o_hburst[g]),
            .hprot        (o_hprot[g]),
            .htrans       (o_htrans[g]),
            .hmastlock    (o_hmastlock[g]),
            .hwdata       (o_hwdata[g]),
            .hready       (hready),
            .hresp        (hresp),
            .hrdata       (hrdata)
        );
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the address phase (-1 none), who owns the
    // data phase, and who won most recently. Instance i uses round-robin iff i==1.
    int own [2] = '{-1, -1};
    int dpo [2] = '{-1, -1};
    int lastg [2] = '{1, 1};

    function automatic logic req_of(input int m);
        return (m == 0) ? m0_bus_req : m1_bus_req;
    endfunction

    function automatic logic lock_of(input int m);
        return (m == 0) ? m0_hmastlock : m1_hmastlock;
    endfunction

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                own[i] = -1; dpo[i] = -1; lastg[i] = 1;
            end else if (hready) begin
                dpo[i] = own[i];
                if (own[i] >= 0) begin
                    if (!req_of(own[i]) && !lock_of(own[i])) own[i] = -1;
                end else if (m0_bus_req || m1_bus_req) begin
                    int w;
                    if (m0_bus_req && m1_bus_req) w = (i == 1) ? 1 - lastg[i] : 0;
                    else w = m0_bus_req ? 0 : 1;
                    own[i] = w;
                    lastg[i] = w;
                end
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input int i);
        logic [AW-1:0] a; logic w; logic [2:0] sz, bu; logic [3:0] pr;
        logic [1:0] tr; logic lk; logic [DW-1:0] wd;
        a = '0; w = 1'b0; sz = 3'd0; bu = 3'd0; pr = 4'd0; tr = 2'd0; lk = 1'b0; wd = '0;
        if (own[i] == 0) begin
            a = m0_haddr; w = m0_hwrite; sz = m0_hsize; bu = m0_hburst;
            pr = m0_hprot; tr = m0_htrans; lk = m0_hmastlock;
        end else if (own[i] == 1) begin
            a = m1_haddr; w = m1_hwrite; sz = m1_hsize; bu = m1_hburst;
            pr = m1_hprot; tr = m1_htrans; lk = m1_hmastlock;
        end
        if (dpo[i] == 0) wd = m0_hwdata;
        else if (dpo[i] == 1) wd = m1_hwdata;
        return {own[i] == 0, own[i] == 1, a, w, sz, bu, pr, tr, lk, wd,
                hready & (own[i] == 0 || dpo[i] == 0), hresp & (own[i] == 0 || dpo[i] == 0),
                hready & (own[i] == 1 || dpo[i] == 1), hresp & (own[i] == 1 || dpo[i] == 1),
                hrdata, hrdata};
    endfunction

    function automatic logic [VW-1:0] dut_vec(input int i);
        return {o_ack0[i], o_ack1[i], o_haddr[i], o_hwrite[i], o_hsize[i], o_hburst[i],
                o_hprot[i], o_htrans[i], o_hmastlock[i], o_hwdata[i],
                o_m0_hready[i], o_m0_hresp[i], o_m1_hready[i], o_m1_hresp[i],
                o_m0_hrdata[i], o_m1_hrdata[i]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rand_bundles();
        m0_haddr = {$urandom, $urandom}; m1_haddr = {$urandom, $urandom};
        m0_hwrite = 1'($urandom); m1_hwrite = 1'($urandom);
        m0_hsize = 3'($urandom); m1_hsize = 3'($urandom);
        m0_hburst = 3'($urandom); m1_hburst = 3'($urandom);
        m0_hprot = 4'($urandom); m1_hprot = 4'($urandom);
        m0_htrans = 2'($urandom); m1_htrans = 2'($urandom);
        m0_hwdata = {$urandom, $urandom}; m1_hwdata = {$urandom, $urandom};
        hrdata = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        rst = 1'b1; m0_bus_req = 1'b0; m1_bus_req = 1'b0;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0; hready = 1'b1; hresp = 1'b0;
        rand_bundles();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m0_bus_req = 1'b1; m1_bus_req = 1'b1;
        m0_hmastlock = 1'b1; m1_hmastlock = 1'b1; hready = 1'b1; hresp = 1'b1;
        rand_bundles();
        tick();
        for (int c = 0; c < 2; c++) begin
            rand_bundles();
            hready = (c == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL reset_model rr%0d t=%0t got=%h want=%h", i, $time, dut_vec(i), exp_vec(i));
                end
                vectors++;
                if ({o_ack0[i], o_ack1[i], o_htrans[i], o_haddr[i], o_hwdata[i]} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_zero rr%0d got ack=%b%b htrans=%b haddr=%h hwdata=%h want all 0",
                             i, o_ack0[i], o_ack1[i], o_htrans[i], o_haddr[i], o_hwdata[i]);
                end
            end
            tick();
        end
        rst = 1'b0; m0_bus_req = 1'b0; m1_bus_req = 1'b0;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0; hresp = 1'b0; hready = 1'b1;
        tick();
    endtask

    task automatic test_m1_only();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            rand_bundles();
            m0_bus_req = 1'b0;
            m1_bus_req = (c < 5);
            m1_htrans = (c < 5) ? HTRANS_NSEQ : HTRANS_IDLE;
            hready = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL m1_only_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
                if (c == 0 || c == 1 || c == 5 || c == 6) begin
                    vectors++;
                    if (o_ack1[i] !== (c == 1 || c == 5)) begin
                        miscompares++;
                        $display("FAIL m1_only_ack rr%0d c=%0d got=%b want=%b", i, c, o_ack1[i], (c == 1 || c == 5));
                    end
                end
                if (c == 1) begin
                    vectors++;
                    if (o_haddr[i] !== m1_haddr) begin
                        miscompares++;
                        $display("FAIL m1_only_haddr rr%0d got=%h want=%h", i, o_haddr[i], m1_haddr);
                    end
                end
                if (c == 6) begin
                    vectors++;
                    if (o_htrans[i] !== HTRANS_IDLE) begin
                        miscompares++;
                        $display("FAIL m1_only_handover_htrans rr%0d got=%b want=00", i, o_htrans[i]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_fixed_priority();
        logic [7:0] want0, want1;
        want0 = 8'b0000_1110;
        want1 = 8'b1110_0000;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rand_bundles();
            m0_bus_req = (c < 3);
            m1_bus_req = 1'b1;
            hready = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL priority_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
                vectors++;
                if ({o_ack0[i], o_ack1[i]} !== {want0[c], want1[c]}) begin
                    miscompares++;
                    $display("FAIL priority_acks rr%0d c=%0d got=%b%b want=%b%b", i, c, o_ack0[i], o_ack1[i], want0[c], want1[c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int gseq [2][$];
        logic prev0 [2] = '{1'b0, 1'b0};
        logic prev1 [2] = '{1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 20; c++) begin
            rand_bundles();
            m0_bus_req = (own[1] != 0);
            m1_bus_req = (own[1] != 1);
            hready = 1'b1;
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL rr_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
                if (o_ack0[i] === 1'b1 && !prev0[i]) gseq[i].push_back(0);
                if (o_ack1[i] === 1'b1 && !prev1[i]) gseq[i].push_back(1);
                prev0[i] = (o_ack0[i] === 1'b1);
                prev1[i] = (o_ack1[i] === 1'b1);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (gseq[1].size() <= k || gseq[1][k] != (k % 2)) begin
                miscompares++;
                $display("FAIL rr_alternate grant%0d got=%0d want=%0d", k, (gseq[1].size() > k) ? gseq[1][k] : -1, k % 2);
            end
            vectors++;
            if (gseq[0].size() <= k || gseq[0][k] != 0) begin
                miscompares++;
                $display("FAIL fixed_repeat grant%0d got=%0d want=0", k, (gseq[0].size() > k) ? gseq[0][k] : -1);
            end
        end
    endtask

    task automatic test_burst_no_preempt();
        int beats = 0;
        int m1_pulses = 0;
        int m0_early = 0;
        int m0_leak = 0;
        bit m0_won = 1'b0;
        do_reset();
        for (int c = 0; c < 3000 && !m0_won; c++) begin
            rand_bundles();
            m1_bus_req = (beats < 256);
            m0_bus_req = (c >= 20);
            m1_hburst = HBURST_INCR;
            m1_htrans = (beats == 0) ? HTRANS_NSEQ : (beats < 256) ? HTRANS_SEQ : HTRANS_IDLE;
            m0_htrans = HTRANS_NSEQ;
            hready = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL burst_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
            end
            if (beats < 256) begin
                if (own[0] == 1 && o_m1_hready[0] === 1'b1) m1_pulses++;
                if (o_ack0[0] !== 1'b0 || o_ack0[1] !== 1'b0) m0_early++;
                if (o_m0_hready[0] !== 1'b0 || o_m0_hresp[0] !== 1'b0) m0_leak++;
                if (own[0] == 1 && hready) beats++;
            end
            tick();
            if (own[0] == 0) m0_won = 1'b1;
        end
        vectors++;
        if (m1_pulses != 256) begin
            miscompares++;
            $display("FAIL burst_m1_hready got=%0d want=256", m1_pulses);
        end
        vectors++;
        if (m0_early != 0) begin
            miscompares++;
            $display("FAIL burst_preempt m0_ack cycles got=%0d want=0", m0_early);
        end
        vectors++;
        if (m0_leak != 0) begin
            miscompares++;
            $display("FAIL burst_m0_leak cycles got=%0d want=0", m0_leak);
        end
        vectors++;
        if (!m0_won) begin
            miscompares++;
            $display("FAIL burst_timeout m0 granted got=0 want=1");
        end
    endtask

    task automatic test_handover_stall();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rand_bundles();
            m0_bus_req = (c < 2);
            m1_bus_req = (c >= 2);
            m0_hwrite = 1'b1;
            m0_htrans = (c < 2) ? HTRANS_NSEQ : HTRANS_IDLE;
            hready = !(c >= 3 && c <= 5);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL stall_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
                if (c >= 3 && c <= 6) begin
                    vectors++;
                    if (o_ack1[i] !== 1'b0 || o_hwdata[i] !== m0_hwdata) begin
                        miscompares++;
                        $display("FAIL stall_hold rr%0d c=%0d got ack1=%b hwdata=%h want ack1=0 hwdata=%h",
                                 i, c, o_ack1[i], o_hwdata[i], m0_hwdata);
                    end
                end
                if (c == 7) begin
                    vectors++;
                    if (o_ack1[i] !== 1'b1 || o_hwdata[i] !== '0) begin
                        miscompares++;
                        $display("FAIL stall_release rr%0d got ack1=%b hwdata=%h want ack1=1 hwdata=0",
                                 i, o_ack1[i], o_hwdata[i]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_hresp();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rand_bundles();
            m0_bus_req = (c >= 2);
            m1_bus_req = 1'b1;
            m1_hwrite = 1'b0;
            m1_htrans = (c == 0) ? HTRANS_NSEQ : HTRANS_SEQ;
            hready = 1'b1;
            hresp = (c == 3 || c == 4);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL hresp_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
                if (c == 3) begin
                    vectors++;
                    if ({o_m1_hresp[i], o_m0_hresp[i]} !== 2'b10) begin
                        miscompares++;
                        $display("FAIL hresp_route rr%0d got m1=%b m0=%b want m1=1 m0=0", i, o_m1_hresp[i], o_m0_hresp[i]);
                    end
                end
                if (c >= 5) begin
                    vectors++;
                    if ({o_ack1[i], o_ack0[i]} !== 2'b10) begin
                        miscompares++;
                        $display("FAIL hresp_keep_grant rr%0d c=%0d got ack1=%b ack0=%b want 1 0", i, c, o_ack1[i], o_ack0[i]);
                    end
                end
            end
            tick();
        end
        hresp = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            rand_bundles();
            m0_bus_req = 1'b0;
            m1_bus_req = 1'b1;
            m1_htrans = (c == 0) ? HTRANS_NSEQ : HTRANS_SEQ;
            hready = 1'b1;
            rst = (c == 3);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL rst_mid_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
                if (c == 3 || c == 4) begin
                    vectors++;
                    if ({o_ack0[i], o_ack1[i], o_htrans[i]} !== ((c == 3) ? {2'b01, HTRANS_SEQ} : {2'b00, HTRANS_IDLE})) begin
                        miscompares++;
                        $display("FAIL rst_mid rr%0d c=%0d got ack=%b%b htrans=%b", i, c, o_ack0[i], o_ack1[i], o_htrans[i]);
                    end
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rand_bundles();
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) m0_bus_req = !m0_bus_req;
            if ($urandom_range(0, 5) == 0) m1_bus_req = !m1_bus_req;
            m0_hmastlock = ($urandom_range(0, 7) == 0);
            m1_hmastlock = ($urandom_range(0, 7) == 0);
            hready = ($urandom_range(0, 4) != 0);
            hresp = ($urandom_range(0, 9) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL random_model rr%0d c=%0d got=%h want=%h", i, c, dut_vec(i), exp_vec(i));
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m0_bus_req = 1'b0; m1_bus_req = 1'b0;
        m0_hmastlock = 1'b0; m1_hmastlock = 1'b0;
        hready = 1'b1; hresp = 1'b0;
        rand_bundles();
        test_reset();
        test_m1_only();
        test_fixed_priority();
        test_round_robin();
        test_burst_no_preempt();
        test_handover_stall();
        test_hresp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
